// File: rtl/rv_instr_encoder.sv
// RV32I field-level instruction encoder that loads assembled words into imem at auto-incrementing addresses.
// Optional build macro ENC_WRAP_EN: wrap the address ring and pulse full instead of entering the FULL state.
module rv_instr_encoder #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_class,
  input  logic [2:0]        in_funct3,
  input  logic              in_alt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [20:0]       in_imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam int unsigned       CNT_W   = ADDR_W + 1;
  localparam int unsigned       CAP     = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
  localparam logic [CNT_W-1:0]  CAP_CNT = CNT_W'(CAP);

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_RANGE   = 2'd2;
  localparam logic [1:0] ERR_ALIGN   = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_FULL} state_t;

  state_t            state;
  logic [31:0]       enc_word;
  logic [1:0]        enc_code;
  logic [6:0]        f7;
  logic              is_shift;
  logic              imm12_ok;
  logic              imm13_ok;
  logic              shamt_ok;
  logic [ADDR_W-1:0] addr_inc;
  logic [CNT_W-1:0]  count_inc;

  // A value fits a signed N-bit field when every bit above N-1 equals the sign bit.
  assign imm12_ok  = (&in_imm[20:11]) | ~(|in_imm[20:11]);
  assign imm13_ok  = (&in_imm[20:12]) | ~(|in_imm[20:12]);
  assign shamt_ok  = ~(|in_imm[20:5]);
  assign is_shift  = (in_class == 3'd3) && ((in_funct3 == 3'b001) || (in_funct3 == 3'b101));
  assign f7        = in_alt ? 7'b0100000 : 7'b0000000;
  assign addr_inc  = mem_addr + ADDR_W'(1);
  assign count_inc = count + CNT_W'(1);

  // Field assembly and legality check for the presented request.
  always_comb begin
    enc_word = '0;
    enc_code = ERR_NONE;
    case (in_class)
      3'd0: enc_word = {f7, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
      3'd1: begin
        enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0000011};
        if (!imm12_ok) enc_code = ERR_RANGE;
      end
      3'd2: begin
        enc_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b1100111};
        if (!imm12_ok) enc_code = ERR_RANGE;
      end
      3'd3: begin
        if (is_shift) begin
          enc_word = {f7, in_imm[4:0], in_rs1, in_funct3, in_rd, 7'b0010011};
          if (!shamt_ok) enc_code = ERR_RANGE;
        end else begin
          enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
          if (!imm12_ok) enc_code = ERR_RANGE;
        end
      end
      3'd4: begin
        enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], 7'b0100011};
        if (!imm12_ok) enc_code = ERR_RANGE;
      end
      3'd5: begin
        enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                    in_imm[4:1], in_imm[11], 7'b1100011};
        if (!imm13_ok)     enc_code = ERR_RANGE;
        else if (in_imm[0]) enc_code = ERR_ALIGN;
      end
      3'd6: begin
        // The 21-bit immediate port already spans the whole J range.
        enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, 7'b1101111};
        if (in_imm[0]) enc_code = ERR_ALIGN;
      end
      default: enc_code = ERR_ILLEGAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      mem_we    <= 1'b0;
      mem_addr  <= BASE;
      mem_wdata <= '0;
      count     <= '0;
      full      <= 1'b0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
    end else if (clear) begin
      state    <= S_IDLE;
      in_ready <= 1'b1;
      mem_we   <= 1'b0;
      mem_addr <= BASE;
      count    <= '0;
      full     <= 1'b0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
    end else begin
`ifdef ENC_WRAP_EN
      full <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            if (enc_code == ERR_NONE) begin
              mem_wdata <= enc_word;
              mem_we    <= 1'b1;
              in_ready  <= 1'b0;
              state     <= S_WRITE;
            end else begin
              err <= 1'b1;
              if (!err) err_code <= enc_code;
            end
          end
        end
        S_WRITE: begin
          if (mem_ready) begin
            mem_we   <= 1'b0;
            mem_addr <= addr_inc;
`ifdef ENC_WRAP_EN
            count    <= (count == CAP_CNT) ? count : count_inc;
            in_ready <= 1'b1;
            state    <= S_IDLE;
            if (addr_inc == BASE) full <= 1'b1;
`else
            count <= count_inc;
            if (count_inc == CAP_CNT) begin
              full  <= 1'b1;
              state <= S_FULL;
            end else begin
              in_ready <= 1'b1;
              state    <= S_IDLE;
            end
`endif
          end
        end
        S_FULL: begin
          in_ready <= 1'b0;
          mem_we   <= 1'b0;
        end
        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b1;
          mem_we   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/rv_instr_encoder.md
Name: rv_instr_encoder

Overview:
- Sequential RV32I instruction encoder/loader: the writer side of the opcode/control decode path.
- Accepts field-level instruction requests over a valid/ready handshake and assembles 32-bit RV32I words.
- Writes each word into instruction memory at an auto-incrementing word address.
- Used by test harnesses and the boot loader to populate imem before the core runs.

Parameters:
- ADDR_W, 8: word-address width; capacity 2^ADDR_W words.
- BASE_ADDR, 0: first word address written after reset/clear.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- clear  in  1  sync restart: count/address/err to initial values
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid&in_ready at rising edge
- in_class  in  3  0 R(0110011), 1 LOAD(0000011), 2 JALR(1100111), 3 I(0010011), 4 S(0100011), 5 B(1100011), 6 J(1101111), 7 illegal
- in_funct3  in  3  funct3
- in_alt  in  1  selects funct7=0100000 (R), or shift imm[11:5]=0100000 (I with funct3 001/101)
- in_rd, in_rs1, in_rs2  in  5 each  register indices
- in_imm  in  21  signed immediate, byte offset for B/J
- mem_we  out  1  write strobe, held until mem_ready
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  32  encoded instruction
- mem_ready  in  1  memory accepts write this cycle
- count  out  ADDR_W+1  words written since reset/clear
- full  out  1  capacity reached
- err  out  1  sticky error flag
- err_code  out  2  first error: 1 ILLEGAL_CLASS, 2 IMM_RANGE, 3 MISALIGN

Behaviour:
- Reset values: in_ready=1, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, count=0, full=0, err=0, err_code=0.
- FSM states: IDLE, WRITE, FULL.
- IDLE: in_ready=1. On accept:
  - Legal request: register the encoded word, go to WRITE. mem_we rises the cycle after accept (1-cycle latency).
  - Illegal request: drop it (no write), set err; record err_code only if err was 0. Stay in IDLE.
- WRITE: in_ready=0, mem_we=1, addr/data stable. On mem_ready: increment count and mem_addr, drop mem_we. Go to FULL if count reaches 2^ADDR_W, else IDLE. Throughput: at most one word per 2 cycles.
- FULL: in_ready=0, full=1, mem_we=0. Leave only via clear or rst.
- clear: highest priority after rst, valid from any state. Same-cycle in_valid is not accepted. A clear during WRITE abandons the write: mem_we=0 next cycle, count not incremented.
- Encoding: opcode comes from in_class.
  - R: {funct7, rs2, rs1, f3, rd, op}.
  - I/LOAD/JALR: {imm[11:0], rs1, f3, rd, op}. JALR forces f3=000. I with f3 001/101 uses {alt?0100000:0000000, imm[4:0]}.
  - S: {imm[11:5], rs2, rs1, f3, imm[4:0], op}.
  - B: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}.
  - Unused fields are ignored.
- Checks, in priority order:
  - class 7 → code 1.
  - I/LOAD/JALR/S imm outside −2048..2047 → code 2. Shift imm outside 0..31 → code 2.
  - B imm outside −4096..4095, or J imm outside −2^20..2^20−1 → code 2.
  - B/J with imm[0]=1 → code 3.
- mem_addr wraps modulo 2^ADDR_W; with BASE_ADDR≠0, full still triggers after 2^ADDR_W writes.

Optional Feature:
- ENC_WRAP_EN defined: the FULL state is never entered.
  - After the 2^ADDR_W-th write, mem_addr returns to BASE_ADDR and count saturates at 2^ADDR_W.
  - full pulses for one cycle on each wrap.
  - in_ready stays 1 in IDLE.
- Undefined: FULL behaviour as above.

Test Plan:
- I class, rd=1, rs1=0, f3=0, imm=5 → mem_we the cycle after accept, mem_addr=0, mem_wdata=0x00500093. After mem_ready: count=1, mem_addr=1.
- Sequence R (rd=3, rs1=1, rs2=2, f3=0, alt=1), then S (rs1=1, rs2=2, f3=010, imm=8) → 0x402081B3 at addr 0, then 0x0020A423 at addr 1.
- B (rs1=1, rs2=2, f3=0, imm=8) → 0x00208463. J (rd=0, imm=−4) → 0xFFDFF06F. Hold mem_ready=0 for 3 cycles → mem_we, addr and data stable; in_ready=0.
- Errors:
  - I imm=2048 → no write, err=1, err_code=2.
  - Then B imm=5 → err_code stays 2.
  - clear → err=0.
  - Then B imm=5 → err_code=3.
  - class 7 after a new clear → err_code=1.
- ADDR_W=2: four legal writes → full=1, in_ready=0, 5th request held. clear → count=0, mem_addr=0, in_ready=1. With ENC_WRAP_EN: 5th word written at addr 0.
- clear asserted in WRITE while mem_ready=0 → mem_we=0 next cycle, count unchanged. rst mid-WRITE → all outputs at reset values.
